// File: rtl/spraid_fifo_pkg.sv
// spraid_fifo_pkg: shared sizing helpers and default geometry for the spraid
// datapath buffers (SPI front-end to RAID striping).
package spraid_fifo_pkg;

    localparam int SPRAID_WIDTH = 32;
    localparam int SPRAID_DEPTH = 8;

    // Pointer width for a DEPTH-entry buffer; a 1-entry buffer still needs one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: one extra bit so the value DEPTH fits.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: WIDTH x DEPTH simple dual-port array, synchronous write and
// asynchronous read. The contents are not reset.
module fifo_ram
    import spraid_fifo_pkg::*;
#(
    parameter int WIDTH = SPRAID_WIDTH,
    parameter int DEPTH = SPRAID_DEPTH,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // Write port: store the word on the edge that accepts the push.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with a true occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; when it is left
// undefined, reads are registered and have one cycle of latency.
module sync_fifo_flags
    import spraid_fifo_pkg::*;
#(
    parameter int WIDTH         = SPRAID_WIDTH,
    parameter int DEPTH         = SPRAID_DEPTH,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] ram_rdata;
    logic             wr_ok, rd_ok;

    // A pop frees a slot in the same cycle, so a push at full still goes
    // through when it is paired with a pop.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    // Every flag is decoded from the registered level and adds no latency.
    assign full         = (level == LW'(DEPTH));
    assign empty        = (level == '0);
    assign almost_full  = (level >= LW'(AFULL_THRESH));
    assign almost_empty = (level <= LW'(AEMPTY_THRESH));

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Pointer and occupancy update. The pointers wrap DEPTH-1 -> 0 naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags. A new error outranks clr_err in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (wr_en && !wr_ok) overflow  <= 1'b1;
            if (rd_en && !rd_ok) underflow <= 1'b1;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // The head word is always presented, and rd_en acknowledges it.
    assign dout       = ram_rdata;
    assign dout_valid = !empty;
`else
    // Registered read: the popped word appears one cycle later, with a
    // one-cycle valid pulse. dout holds its value between pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_ok;
            if (rd_ok) dout <= ram_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed stimulus with a scoreboard. Accepted pushes
// enqueue the expected words, and a negedge monitor compares each word the
// DUT presents against that queue.
module tb_sync_fifo_flags;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en, rd_en, clr_err;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid, full, empty, almost_full, almost_empty;
    logic [3:0]       level;
    logic             overflow, underflow;

    int checks = 0;
    int errors = 0;
    int mlvl   = 0;
    logic [WIDTH-1:0] exp_q[$];

    sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(6), .AEMPTY_THRESH(2)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. The bench's own occupancy model decides which
    // pushes are accepted, and each accepted push enqueues its expected word.
    task automatic op(input logic w, input logic [31:0] d, input logic r, input logic c = 1'b0);
        bit acc_r, acc_w;
        wr_en = w; din = d; rd_en = r; clr_err = c;
        acc_r = r && (mlvl > 0);
        acc_w = w && ((mlvl < DEPTH) || acc_r);
        if (acc_w) exp_q.push_back(d);
        mlvl = mlvl + int'(acc_w) - int'(acc_r);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: compare each presented word against the scoreboard.
    always @(negedge clk) begin
`ifdef SYNC_FIFO_FWFT_EN
        if (dout_valid && rd_en && !reset) begin
`else
        if (dout_valid && !reset) begin
`endif
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_read: got 0x%0h expected no word at %0t", dout, $time);
            end else begin
                chk("dout_order", dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
        idle(2);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_afull", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        chk("rst_dvalid", dout_valid, 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst_dout", dout, 0);
`endif
        reset = 1'b0;
        idle(1);

        // Fill with 0x11..0x88 and follow the flags at each level.
        for (int i = 1; i <= 8; i++) begin
            op(1'b1, 32'(i * 'h11), 1'b0);
            chk("fill_level", level, i);
            chk("fill_afull", almost_full, (i >= 6));
            chk("fill_aempty", almost_empty, (i <= 2));
            chk("fill_full", full, (i == 8));
        end
        // Drain. The words come out in order through the monitor.
        for (int i = 1; i <= 8; i++) op(1'b0, 0, 1'b1);
        idle(1);
        chk("drain_level", level, 0);
        chk("drain_empty", empty, 1);
        chk("drain_ovf", overflow, 0);
        chk("drain_udf", underflow, 0);

        // Overflow: 0xDEAD must be dropped.
        for (int i = 1; i <= 8; i++) op(1'b1, 32'('h20 + i), 1'b0);
        op(1'b1, 32'hDEAD, 1'b0);
        chk("ovf_level", level, 8);
        chk("ovf_flag", overflow, 1);
        op(1'b0, 0, 1'b0, 1'b1);
        chk("ovf_clr", overflow, 0);
        // Full with a push and a pop together: both are accepted.
        op(1'b1, 32'hAB, 1'b1);
        chk("fullrw_level", level, 8);
        chk("fullrw_ovf", overflow, 0);
        for (int i = 0; i < 8; i++) op(1'b0, 0, 1'b1);
        idle(1);
        chk("ovf_drained", level, 0);

        // Underflow on an empty FIFO.
        op(1'b0, 0, 1'b1);
        chk("udf_flag", underflow, 1);
        chk("udf_level", level, 0);
        chk("udf_dvalid", dout_valid, 0);
        // A new error in the same cycle as clr_err leaves the flag set.
        op(1'b0, 0, 1'b1, 1'b1);
        chk("udf_set_wins", underflow, 1);
        op(1'b0, 0, 1'b0, 1'b1);
        chk("udf_clr", underflow, 0);

        // Empty with a push and a pop together: only the push is accepted.
        op(1'b1, 32'hCD, 1'b1);
        chk("emptyrw_level", level, 1);
        chk("emptyrw_udf", underflow, 1);
        op(1'b0, 0, 1'b1, 1'b1);
        idle(1);
        chk("emptyrw_after", level, 0);
        chk("emptyrw_clr", underflow, 0);

        // Pointer wrap: hold the level at 3 through 20 push/pop pairs.
        for (int i = 0; i < 3; i++) op(1'b1, 32'('h100 + i), 1'b0);
        for (int i = 3; i < 23; i++) begin
            op(1'b1, 32'('h100 + i), 1'b1);
            if (level !== 4'd3) chk("wrap_level", level, 3);
        end
        chk("wrap_level_end", level, 3);
        for (int i = 0; i < 3; i++) op(1'b0, 0, 1'b1);
        idle(1);
        chk("wrap_drained", level, 0);

        // Async reset mid-stream at level 5, with underflow set and a read
        // result valid at the moment reset is applied.
        op(1'b0, 0, 1'b1);
        for (int i = 0; i < 6; i++) op(1'b1, 32'('h200 + i), 1'b0);
        op(1'b0, 0, 1'b1);
        chk("pre_rst_level", level, 5);
        chk("pre_rst_udf", underflow, 1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        mlvl = 0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_empty", empty, 1);
        chk("arst_dvalid", dout_valid, 0);
        chk("arst_udf", underflow, 0);
        chk("arst_aempty", almost_empty, 1);
        idle(2);
        reset = 1'b0;
        op(1'b1, 32'h55, 1'b0);
        op(1'b0, 0, 1'b1);
        idle(2);
        chk("post_rst_level", level, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parameterised single-clock FIFO, next generation of the datapath buffer between the SPI front-end and the RAID striping logic. Holds the full DEPTH entries, with a true occupancy count and programmable almost-full/almost-empty thresholds. Rejected pushes and pops are protected, and sticky overflow/underflow error flags record them. Read timing is selectable between registered output and first-word-fall-through.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AFULL_THRESH, DEPTH-2, almost_full asserts when level ≥ this value (1..DEPTH)
- AEMPTY_THRESH, 2, almost_empty asserts when level ≤ this value (0..DEPTH-1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  push request
- din  in  WIDTH  push data
- rd_en  in  1  pop request (FWFT: acknowledge of current head)
- dout  out  WIDTH  read data
- dout_valid  out  1  dout holds valid popped/head data
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level ≥ AFULL_THRESH
- almost_empty  out  1  level ≤ AEMPTY_THRESH
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected
- clr_err  in  1  synchronous clear of overflow/underflow

## Operation
- Reset: wr_ptr=0, rd_ptr=0, level=0, overflow=0, underflow=0, dout=0, dout_valid=0. Outputs: empty=1, full=0, almost_empty=1, almost_full=0. Storage array is not reset.
- Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 → 0 naturally.
- Push accepted (wr_ok) when wr_en && (!full || rd_ok). Pop accepted (rd_ok) when rd_en && !empty.
- Accepted push: mem[wr_ptr] ← din, wr_ptr+1. Accepted pop: rd_ptr+1.
- Level: +1 on push only, −1 on pop only, unchanged when both or neither.
- Full with rd_en && wr_en: both accepted, level stays DEPTH.
- Empty with rd_en && wr_en: only the push is accepted; level → 1; underflow set.
- wr_en while full and no accepted pop: data dropped, state unchanged, overflow ← 1.
- rd_en while empty: no pointer change, underflow ← 1.
- Sticky flags: clr_err clears both; if a new error and clr_err coincide, the set wins.
- Flags are decoded combinationally from registered level; no extra latency.

## Timing
- Push→visible: level/empty update on the edge that accepts the push. Data is poppable from the next cycle.
- Registered mode (no macro): on an accepted pop, dout ← mem[rd_ptr] and dout_valid=1 on the following cycle, a 1-cycle pulse per pop. Otherwise dout holds its last value and dout_valid=0.
- FWFT mode: see Configuration.
- Reset asserted mid-operation clears all state asynchronously. Contents are lost, and dout_valid drops in the same cycle.

## Configuration
- SYNC_FIFO_FWFT_EN defined: dout = mem[rd_ptr] combinationally and dout_valid = !empty. rd_en acknowledges the presented word, with zero read latency. Registered dout and its reset term are removed.
- Undefined: registered read with 1-cycle latency, as in Timing.

## Structure
- Shared package spraid_fifo_pkg holds:
  - the pointer/level width helper (clog2-based)
  - default WIDTH/DEPTH constants used across spraid buffers
- One sub-module, fifo_ram: simple dual-port array (sync write, async read, no reset), WIDTH×DEPTH. Control, pointers, flags and the output register live in sync_fifo_flags.

## Test plan
- Reset then fill: 8 pushes of 0x11..0x88 (DEPTH=8) → level=8, full=1, almost_full set from level 6. Then 8 pops → 0x11..0x88 in order, empty=1, no errors.
- Overflow: full, push 0xDEAD without rd_en → level stays 8, overflow=1, 0xDEAD never read. clr_err → overflow=0.
- Underflow: empty, rd_en for 1 cycle → underflow=1, level=0, dout_valid=0, pointers unchanged.
- Simultaneous: at full, rd_en+wr_en(0xAB) → level=8, oldest word read, 0xAB read last. At empty, rd_en+wr_en(0xCD) → level=1, underflow=1, 0xCD read next.
- Wrap: 20 push/pop pairs interleaved at level 3 → data order preserved across pointer wrap, level constant at 3.
- Async reset mid-stream at level 5 → level=0, empty=1, dout_valid=0, flags cleared immediately, without waiting for a clock edge.
